// File: rtl/npu_seq_pkg.sv
// Shared types and constants for the NPU job sequencer.
// Pure declarations; no logic, no latency; no flow control.
package npu_seq_pkg;

    localparam int CFG_WORDS = 6;
    localparam int WDOG_W    = 16;

    localparam logic [3:0] ENC_IDLE = 4'd0;
    localparam logic [3:0] ENC_PRE  = 4'd1;
    localparam logic [3:0] ENC_CFG  = 4'd2;
    localparam logic [3:0] ENC_WGT  = 4'd3;
    localparam logic [3:0] ENC_INP  = 4'd4;
    localparam logic [3:0] ENC_CALC = 4'd5;
    localparam logic [3:0] ENC_READ = 4'd6;
    localparam logic [3:0] ENC_FIN  = 4'd7;
    localparam logic [3:0] ENC_ERR  = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE = ENC_IDLE,
        ST_PRE  = ENC_PRE,
        ST_CFG  = ENC_CFG,
        ST_WGT  = ENC_WGT,
        ST_INP  = ENC_INP,
        ST_CALC = ENC_CALC,
        ST_READ = ENC_READ,
        ST_FIN  = ENC_FIN,
        ST_ERR  = ENC_ERR
    } state_e;

    function automatic logic is_stream(state_e s);
        return (s == ST_WGT) || (s == ST_INP);
    endfunction

    function automatic logic drives_we(state_e s);
        return (s == ST_PRE) || (s == ST_CFG) || (s == ST_WGT) || (s == ST_INP);
    endfunction

    function automatic logic drives_bus(state_e s);
        return (s == ST_CFG) || (s == ST_WGT) || (s == ST_INP);
    endfunction

endpackage

// File: rtl/npu_seq_counter.sv
// Loadable down-counter with zero flag, shared by all timed sequencer phases.
// Load takes effect on the next edge; otherwise decrements once per cycle.
// No backpressure; holds at zero instead of wrapping.
module npu_seq_counter #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/npu_job_sequencer.sv
// Drives one NPU job (preamble, 6 cfg words, weights, inputs, compute wait, readback) on the we/oe bus.
// Results appear 1 cycle after each oe cycle; done pulses in FIN/ERR. Optional NPU_SEQ_READY_WAIT_EN gates CALC on npu_ready.
// The NPU cannot stall: a missing stream word in WGT/INP aborts to ERR; results have no backpressure.
module npu_job_sequencer
    import npu_seq_pkg::*;
#(
    parameter int DW     = 32,
    parameter int WCNT_W = 12,
    parameter int CALC_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        cfg_layers_i,
    input  logic [4:0]        cfg_in_i,
    input  logic [4:0]        cfg_h1_i,
    input  logic [4:0]        cfg_h2_i,
    input  logic [4:0]        cfg_out_i,
    input  logic [1:0]        cfg_act_i,
    input  logic [WCNT_W-1:0] cfg_nw_i,
    input  logic [CALC_W-1:0] cfg_calc_i,
    input  logic              src_valid_i,
    input  logic [DW-1:0]     src_data_i,
    output logic              src_ready_o,
    output logic              npu_we_o,
    output logic              npu_oe_o,
    output logic [DW-1:0]     npu_dout_o,
    output logic              npu_dout_en_o,
    input  logic [DW-1:0]     npu_din_i,
    input  logic              npu_ready_i,
    output logic              res_valid_o,
    output logic [DW-1:0]     res_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // One counter serves every phase, so it must hold the widest phase length.
    localparam int CW = WCNT_W;

    state_e            state_q, state_d;
    logic [1:0]        layers_q, act_q;
    logic [4:0]        in_q, h1_q, h2_q, out_q;
    logic [WCNT_W-1:0] nw_q;
    logic [CALC_W-1:0] calc_q;
    logic              we_q, oe_q, den_q, busy_q, done_q, err_q, res_vld_q;
    logic [DW-1:0]     res_dat_q;
    logic              cnt_load, cnt_zero;
    logic [CW-1:0]     cnt_val, cnt, calc_load;
    logic [DW-1:0]     cfg_word;
    logic              accept, calc_done, wdog_ovf, skip_calc;

    assign accept    = (state_q == ST_IDLE) && start_i;
    assign calc_load = (calc_q == '0) ? '0 : CW'(calc_q) - CW'(1);

`ifdef NPU_SEQ_READY_WAIT_EN
    logic [WDOG_W-1:0] wdog_q;

    assign calc_done = cnt_zero && npu_ready_i;
    assign wdog_ovf  = &wdog_q;
    assign skip_calc = (calc_q == '0) && npu_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else if (state_q != ST_CALC) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    logic unused_ready;

    assign unused_ready = npu_ready_i;
    assign calc_done    = cnt_zero;
    assign wdog_ovf     = 1'b0;
    assign skip_calc    = (calc_q == '0);
`endif

    npu_seq_counter #(.W(CW)) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // Counters are loaded with length-1 on entry; a phase ends on the cycle it reads zero.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_PRE;
            ST_PRE: begin
                state_d  = ST_CFG;
                cnt_load = 1'b1;
                cnt_val  = CW'(CFG_WORDS - 1);
            end
            ST_CFG: if (cnt_zero) begin
                state_d  = ST_WGT;
                cnt_load = 1'b1;
                cnt_val  = CW'(nw_q - 1'b1);
            end
            ST_WGT: begin
                if (!src_valid_i) begin
                    state_d = ST_ERR;
                end else if (cnt_zero) begin
                    state_d  = ST_INP;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(in_q);
                end
            end
            ST_INP: begin
                if (!src_valid_i) begin
                    state_d = ST_ERR;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (skip_calc) begin
                        state_d = ST_READ;
                        cnt_val = CW'(out_q);
                    end else begin
                        state_d = ST_CALC;
                        cnt_val = calc_load;
                    end
                end
            end
            ST_CALC: begin
                if (calc_done) begin
                    state_d  = ST_READ;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(out_q);
                end else if (wdog_ovf) begin
                    state_d = ST_ERR;
                end
            end
            ST_READ: if (cnt_zero) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_word = '0;
        case (cnt)
            CW'(5):  cfg_word = DW'(layers_q);
            CW'(4):  cfg_word = DW'(in_q);
            CW'(3):  cfg_word = DW'(h1_q);
            CW'(2):  cfg_word = DW'(h2_q);
            CW'(1):  cfg_word = DW'(out_q);
            CW'(0):  cfg_word = DW'(act_q);
            default: cfg_word = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            layers_q  <= '0;
            in_q      <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            out_q     <= '0;
            act_q     <= '0;
            nw_q      <= '0;
            calc_q    <= '0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            den_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= drives_we(state_d);
            oe_q      <= (state_d == ST_READ);
            den_q     <= drives_bus(state_d);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_FIN) || (state_d == ST_ERR);
            res_vld_q <= (state_q == ST_READ);
            if (state_q == ST_READ) res_dat_q <= npu_din_i;
            if (accept) begin
                layers_q <= cfg_layers_i;
                in_q     <= cfg_in_i;
                h1_q     <= cfg_h1_i;
                h2_q     <= cfg_h2_i;
                out_q    <= cfg_out_i;
                act_q    <= cfg_act_i;
                nw_q     <= cfg_nw_i;
                calc_q   <= cfg_calc_i;
                err_q    <= 1'b0;
            end else if (state_d == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign src_ready_o   = src_valid_i && is_stream(state_q);
    assign npu_dout_o    = (state_q == ST_CFG) ? cfg_word :
                           is_stream(state_q)  ? src_data_i : '0;
    assign npu_we_o      = we_q;
    assign npu_oe_o      = oe_q;
    assign npu_dout_en_o = den_q;
    assign res_valid_o   = res_vld_q;
    assign res_data_o    = res_dat_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_npu_job_sequencer.sv
// Scoreboard bench for npu_job_sequencer: a job-level timing model queues expected bus events, a monitor pops them.
module tb_npu_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [1:0]  cfg_layers, cfg_act;
    logic [4:0]  cfg_in, cfg_h1, cfg_h2, cfg_out;
    logic [11:0] cfg_nw;
    logic [7:0]  cfg_calc;
    logic        src_valid, src_ready;
    logic [31:0] src_data, dout, din, res_data;
    logic        we, oe, dout_en, npu_ready, res_valid, busy, done, err;

    npu_job_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .cfg_layers_i(cfg_layers), .cfg_in_i(cfg_in), .cfg_h1_i(cfg_h1),
        .cfg_h2_i(cfg_h2), .cfg_out_i(cfg_out), .cfg_act_i(cfg_act),
        .cfg_nw_i(cfg_nw), .cfg_calc_i(cfg_calc),
        .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready),
        .npu_we_o(we), .npu_oe_o(oe), .npu_dout_o(dout), .npu_dout_en_o(dout_en),
        .npu_din_i(din), .npu_ready_i(npu_ready),
        .res_valid_o(res_valid), .res_data_o(res_data),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic en; logic [31:0] dat; } ev_t;
    typedef struct { int layers, in, h1, h2, out, act, nw, calc; } cfg_t;

    ev_t wq[$], rq[$], dq[$];
    int  oq[$];
    int  n_chk = 0, n_pass = 0;
    int  cons = 0, sbase = 0;
    int  win_lo = -1, win_hi = -2, drop_cyc = -1;

    function automatic logic [31:0] wfun(int i);
        return 32'(i) * 32'h9E3779B1 + 32'h0000_1234;
    endfunction

    function automatic logic [31:0] din_fun(int c);
        return (32'(c) * 32'h85EBCA6B) ^ 32'hC0FF_EE00;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cyc %0d: got %0h, required %0h", nm, cyc, got, exp);
    endtask

    task automatic unexpected(string nm);
        n_chk++;
        $display("FAIL %s at cyc %0d: got an event, required none", nm, cyc);
    endtask

    // Stream source, NPU read data, and stream valid; all change just after the clock edge.
    always @(posedge clk) begin
        #1;
        src_data = wfun(cons);
        din      = din_fun(cyc);
        if (cyc >= win_lo && cyc <= win_hi) src_valid = (cyc != drop_cyc);
        else                                src_valid = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        ev_t e;
        if (src_valid && src_ready) cons++;
        chk("we_oe_exclusive", {31'b0, we & oe}, 32'd0);
        chk("dout_en_implies_we", {31'b0, dout_en & ~we}, 32'd0);
        if (!dout_en) chk("dout_idle_zero", dout, 32'd0);
        if (we) begin
            if (wq.size() == 0) unexpected("we");
            else begin
                e = wq.pop_front();
                chk("we_cycle", cyc, e.cyc);
                chk("dout_en", {31'b0, dout_en}, {31'b0, e.en});
                chk("dout", dout, e.dat);
                if (!e.en) chk("err_clear_at_pre", {31'b0, err}, 32'd0);
            end
        end
        if (oe) begin
            if (oq.size() == 0) unexpected("oe");
            else chk("oe_cycle", cyc, oq.pop_front());
        end
        if (res_valid) begin
            if (rq.size() == 0) unexpected("res_valid");
            else begin
                e = rq.pop_front();
                chk("res_cycle", cyc, e.cyc);
                chk("res_data", res_data, e.dat);
            end
        end
        if (done) begin
            if (dq.size() == 0) unexpected("done");
            else begin
                e = dq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("err_at_done", {31'b0, err}, {31'b0, e.en});
                chk("busy_at_done", {31'b0, busy}, 32'd1);
            end
        end
    end

    // Job-level model: event times from phase lengths, stream data from the global word index.
    task automatic plan_job(input int t, input cfg_t c, input int d, output int done_c);
        int w[6];
        int total, nwr, tc, tr;
        w = '{c.layers, c.in, c.h1, c.h2, c.out, c.act};
        wq.push_back('{t + 1, 1'b0, 32'd0});
        for (int i = 0; i < 6; i++) wq.push_back('{t + 2 + i, 1'b1, 32'(w[i])});
        total = c.nw + c.in + 1;
        nwr   = (d >= 0) ? d + 1 : total;
        for (int i = 0; i < nwr; i++) wq.push_back('{t + 8 + i, 1'b1, wfun(sbase + i)});
        win_lo = t + 8;
        if (d >= 0) begin
            drop_cyc = t + 8 + d;
            win_hi   = t + 8 + d;
            done_c   = t + 9 + d;
            dq.push_back('{done_c, 1'b1, 32'd0});
            sbase += d;
        end else begin
            drop_cyc = -1;
            win_hi   = t + 7 + total;
            tc = t + 8 + total;
            tr = tc + c.calc;
            for (int j = 0; j <= c.out; j++) begin
                oq.push_back(tr + j);
                rq.push_back('{tr + 1 + j, 1'b1, din_fun(tr + j)});
            end
            done_c = tr + c.out + 1;
            dq.push_back('{done_c, 1'b0, 32'd0});
            sbase += total;
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        cfg_layers = 2'(c.layers); cfg_in = 5'(c.in); cfg_h1 = 5'(c.h1); cfg_h2 = 5'(c.h2);
        cfg_out = 5'(c.out); cfg_act = 2'(c.act); cfg_nw = 12'(c.nw); cfg_calc = 8'(c.calc);
    endtask

    task automatic scramble_cfg();
        {cfg_layers, cfg_in, cfg_h1, cfg_h2} = 17'($urandom);
        {cfg_out, cfg_act} = 7'($urandom);
        cfg_nw = 12'($urandom);
        cfg_calc = 8'($urandom);
    endtask

    // Called just after a clock edge; that cycle is the start cycle T.
    task automatic run_job(input cfg_t c, input int d, input bit glitch);
        int t, done_c, g;
        t = cyc;
        drive_cfg(c);
        start = 1'b1;
        plan_job(t, c, d, done_c);
        g = glitch ? int'($urandom_range(done_c - 1, t + 2)) : -1;
        while (cyc < done_c + 1) begin
            @(posedge clk); #1;
            start = (cyc == g);
            scramble_cfg();
        end
        start = 1'b0;
        win_lo = -1; win_hi = -2; drop_cyc = -1;
        chk("busy_after_done", {31'b0, busy}, 32'd0);
        chk("queues_drained", wq.size() + oq.size() + rq.size() + dq.size(), 32'd0);
    endtask

    task automatic reset_mid_wgt(input cfg_t c, input int k);
        int t, done_c, base0;
        t = cyc;
        base0 = sbase;
        drive_cfg(c);
        start = 1'b1;
        plan_job(t, c, -1, done_c);
        while (cyc < t + 8 + k) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we", {31'b0, we}, 32'd0);
        chk("rst_oe", {31'b0, oe}, 32'd0);
        chk("rst_dout_en", {31'b0, dout_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        wq.delete(); oq.delete(); rq.delete(); dq.delete();
        sbase = base0 + k;
        win_lo = -1; win_hi = -2; drop_cyc = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic rand_job();
        cfg_t c;
        int d, gap;
        c.layers = $urandom_range(0, 3); c.in = $urandom_range(0, 12);
        c.h1 = $urandom_range(0, 31); c.h2 = $urandom_range(0, 31);
        c.out = $urandom_range(0, 5); c.act = $urandom_range(0, 3);
        c.nw = $urandom_range(1, 24); c.calc = $urandom_range(0, 8);
        d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, c.nw + c.in)) : -1;
        run_job(c, d, 1'($urandom_range(0, 1)));
        gap = $urandom_range(0, 2);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; npu_ready = 1'b0;
        src_valid = 1'b0; src_data = '0; din = '0;
        drive_cfg('{0, 0, 0, 0, 0, 0, 1, 0});
        repeat (3) @(posedge clk);
        #1;
        chk("reset_we", {31'b0, we}, 32'd0);
        chk("reset_oe", {31'b0, oe}, 32'd0);
        chk("reset_dout_en", {31'b0, dout_en}, 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job('{0, 9, 0, 0, 0, 0, 11, 5}, -1, 1'b0);
        run_job('{2, 9, 4, 3, 1, 2, 3, 0}, -1, 1'b1);
        run_job('{1, 3, 2, 2, 1, 1, 8, 2}, 4, 1'b1);
        chk("err_sticky", {31'b0, err}, 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        chk("err_still_sticky", {31'b0, err}, 32'd1);
        run_job('{3, 2, 7, 5, 2, 3, 4, 1}, -1, 1'b1);
        chk("err_cleared", {31'b0, err}, 32'd0);
        reset_mid_wgt('{1, 4, 3, 3, 1, 1, 9, 3}, 3);
        run_job('{0, 9, 0, 0, 0, 0, 11, 5}, -1, 1'b0);
        for (int n = 0; n < 25; n++) rand_job();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/npu_job_sequencer.md
Name: npu_job_sequencer

Overview:
- Host-side controller that drives one complete NPU job over the NPU's shared we/oe/data word bus.
- Job order: configuration words, weight/bias stream, input vector, a compute wait, then output readback.
- Sits between a host/DMA stream interface and the NPU top.
- Replaces hand-timed testbench sequencing with a synthesizable FSM, so benchmarks (e.g. the 65536-set hotspot run) can loop back-to-back jobs.

Parameters:
- DW, 32, data word width.
- WCNT_W, 12, width of weight-count field (matches weight-array index width).
- CALC_W, 8, width of compute-wait counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle job request; sampled only in IDLE.
- cfg_layers  in  2  num_layers word (0 = 2 layers).
- cfg_in  in  5  num_in word (inputs minus one).
- cfg_h1  in  5  hidden-1 neuron word.
- cfg_h2  in  5  hidden-2 neuron word.
- cfg_out  in  5  num_out word (outputs minus one).
- cfg_act  in  2  activation select word.
- cfg_nw  in  WCNT_W  number of weights+biases; must be ≥1.
- cfg_calc  in  CALC_W  compute-wait cycles.
- src_valid  in  1  weight/input stream word valid.
- src_data  in  DW  stream word; weights first, then inputs.
- src_ready  out  1  stream word consumed this cycle.
- npu_we  out  1  NPU write enable.
- npu_oe  out  1  NPU output enable.
- npu_dout  out  DW  word driven to the NPU bus.
- npu_dout_en  out  1  tristate enable for npu_dout.
- npu_din  in  DW  bus value while npu_oe is high.
- npu_ready  in  1  NPU ready flag.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  DW  captured output word.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  sticky underrun flag; cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; config latches and counters cleared.
- Reset mid-job aborts immediately: we/oe/dout_en drop to 0 asynchronously.
- States: IDLE → PRE → CFG → WGT → INP → CALC → READ → FIN; any → ERR on underrun.
- IDLE:
  - start=1 latches all cfg_*, clears err, sets busy, goes to PRE next cycle.
  - start while busy is ignored.
- PRE (1 cycle): npu_we=1, npu_dout_en=0. This is the preamble cycle.
- CFG (6 cycles): npu_we=1, npu_dout_en=1.
  - Words in order: layers, in, h1, h2, out, act, each zero-extended to DW.
- WGT (cfg_nw cycles), then INP (cfg_in+1 cycles):
  - npu_we=1, npu_dout=src_data, src_ready=src_valid.
  - Exactly one word per cycle.
  - src_valid=0 in either state → ERR. The NPU cannot stall.
- CALC: npu_we=0, npu_dout_en=0.
  - Wait cfg_calc cycles.
  - cfg_calc=0 gives 0 wait cycles: goes straight to READ.
- READ (cfg_out+1 cycles):
  - npu_oe=1.
  - npu_din is registered at each rising edge ending an oe cycle.
  - res_valid/res_data follow 1 cycle later. No backpressure.
- FIN (1 cycle): done=1, busy=0 next cycle, returns to IDLE.
  - The final res_valid coincides with done.
- ERR (1 cycle):
  - we/oe/dout_en=0, err=1 (sticky).
  - done=1, then IDLE.
  - Stream words already consumed are not replayed.
- npu_we and npu_oe are never high together; npu_dout_en implies npu_we.
- All counters are down-counters loaded on state entry; no wrap-around reaches the outputs.
- Unused bus outputs are 0 when not driving.

Optional Feature:
- Macro: NPU_SEQ_READY_WAIT_EN.
- With it: CALC exits only after the cfg_calc minimum has elapsed AND npu_ready=1.
  - A free-running 16-bit watchdog counts CALC cycles.
  - Overflow goes to ERR with err=1.
- Without it: npu_ready is ignored and CALC is a fixed cfg_calc cycles.

Decomposition:
- Package npu_seq_pkg holds:
  - the state enum;
  - CFG_WORDS=6;
  - the watchdog width constant;
  - the state parameter encodings.
- One natural sub-module: npu_seq_counter.
  - Loadable down-counter with zero flag, shared by the CFG/WGT/INP/CALC/READ phases.

Test Plan:
- Config 10_0_0_1: layers=0, in=9, h1=h2=out=0, act=0, nw=11, calc=5; start at cycle T; stream always valid.
  - npu_we high T+1..T+28 (1 preamble + 6 cfg + 11 weights + 10 inputs).
  - npu_oe high at T+34.
  - res_valid+done at T+35 with res_data = npu_din sampled at T+34.
- CFG word check with layers=2, in=9, h1=4, h2=3, out=1, act=2.
  - npu_dout is 2,9,4,3,1,2 on T+2..T+7.
  - Two res_valid pulses during READ.
- Underrun: drop src_valid on the 5th weight.
  - That cycle moves to ERR; next cycle we=0, err=1, done=1.
  - The next start clears err.
- Reset (rst=0) during WGT: we, oe, dout_en=0 asynchronously; busy=0.
  - A start after release runs a clean job.
- start pulsed while busy: ignored.
  - Back-to-back jobs: the start on the cycle after done is accepted.
  - Config latched at start; changing cfg_* mid-job has no effect.
- NPU_SEQ_READY_WAIT_EN, calc=5, npu_ready rises at CALC cycle 9: npu_oe rises the cycle after.
  - With npu_ready held low: watchdog overflow → err=1.
